mtr_drv_gen: RTL and testbench
==============================

Name: mtr_drv_gen

Overview:
Parametrised N-phase motor driver for the eBike commutation path. It combines an internal free-running PWM generator, per-phase commutation muxing, per-phase dead-time insertion with a runtime-programmable dead time, and a latched over-current shutdown. Commutation logic upstream drives it, and its outputs go directly to the gate drivers of N_PH half-bridges.

Parameters:
PWM_W, 11, PWM counter and duty width; period = 2^PWM_W clocks
N_PH, 3, number of half-bridge phases
DT_W, 6, width of dead_time input

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
duty  in  PWM_W  requested duty; sampled once per period
sel  in  2*N_PH  commutation select; phase p uses sel[2p+1:2p]
dead_time  in  DT_W  dead-time length in clocks
ovr_curr  in  1  asynchronous over-current indication from the comparator
flt_clr  in  1  fault clear request, level-sensitive
high  out  N_PH  high-side gate enables
low  out  N_PH  low-side gate enables
PWM_synch  out  1  one-cycle pulse marking PWM period start
fault  out  1  latched over-current fault

Behaviour:
- Reset (async, rst=1): cnt=0, duty_q=0, high=0, low=0, PWM_synch=0, fault=0, sync flops=0, all phase FSMs in DEAD with counter=0, req_prev=00.
- PWM: cnt increments every clock and wraps from 2^PWM_W-1 to 0.
  - When cnt==2^PWM_W-1, duty_q<=duty. Duty changes never take effect mid-period.
  - pwm = (cnt < duty_q). duty_q=0 gives constant low. Maximum duty gives high for 2^PWM_W-1 of 2^PWM_W clocks.
  - PWM_synch is registered and equals 1 exactly in the cycle cnt==0.
- Mux per phase, req={hreq,lreq}:
  - 00 coast: hreq=0, lreq=0.
  - 01 reverse: hreq=~pwm, lreq=pwm.
  - 10 forward: hreq=pwm, lreq=~pwm.
  - 11 brake: hreq=0, lreq=pwm.
- Dead-time FSM per phase, states RUN and DEAD. Let D = max(dead_time,1); 0 is treated as 1, so high and low are never simultaneously 1.
  - req is registered into req_q each clock.
  - RUN: outputs = req_q. If req_q != req_prev, go to DEAD, load counter with D, and force outputs to 0 at the same edge.
  - DEAD: outputs 0. The counter decrements each clock. If req_q changes during DEAD, the counter reloads with D. When the counter reaches 1 (or 0 out of reset), go to RUN and drive req_q.
  - req_prev updates every clock to req_q.
  - Latency: a mux change captured at edge k gives outputs 0 from edge k+1 through edge k+D, and outputs equal the new request at edge k+D+1.
  - dead_time is sampled at each load.
- Fault handling:
  - ovr_curr passes through a 2-flop synchroniser to produce oc_s.
  - When oc_s=1, fault<=1 and all high/low<=0 on the same edge. This overrides RUN and DEAD.
  - While fault=1, outputs stay 0 and all FSMs are held in DEAD with counter=D.
  - fault clears only when flt_clr=1 and oc_s=0. If flt_clr and oc_s are both 1, fault stays set.
  - After a clear, every phase completes a full D-cycle dead window before RUN.
  - The PWM counter keeps running during a fault.
- Reset asserted mid-period returns everything to reset values immediately. After release, the first output drive occurs no earlier than D+1 clocks.
- Invariant at every clock: high[p] & low[p] == 0.

Test Plan:
- PWM/duty timing: PWM_W=11, duty=512, sel=10 on all phases, dead_time=32 -> PWM_synch pulses every 2048 clocks. high[0] is high for 512-32=480 clocks and low[0] for 1536-32=1504 clocks per period, with exactly 32 clocks of both-low at each edge.
- Mid-period duty update: change duty 512->1024 at cnt=100 -> the current period keeps 512. The next period, starting at the PWM_synch pulse, shows 1024.
- Mode coverage on phases 0/1/2 with sel=01/11/00 -> phase0 is inverted relative to forward. Phase1 shows high=0 and low pulsing. Phase2 is all 0.
- dead_time=0 -> treated as 1, giving a 1-clock both-low gap at every transition. Assert high&low==0 throughout.
- Fault: assert ovr_curr at cnt=300 -> fault=1 and outputs 0 within 3 clocks. flt_clr while ovr_curr=1 keeps fault=1. Drop ovr_curr, then pulse flt_clr -> fault=0, then D clocks of both-low before outputs resume.
- Async reset mid-period with outputs active -> all outputs and fault go 0 without a clock edge. After release, cnt restarts at 0 and PWM_synch pulses on the first cnt==0 cycle.

Source files
------------

// File: rtl/mtr_drv_gen.sv
// mtr_drv_gen
//   N-phase half-bridge gate driver for the eBike commutation path.
//   A free-running PWM counter produces one shared PWM waveform. Each
//   phase muxes it into a high/low request according to its commutation
//   select. A two-state dead-time FSM per phase then makes sure the two
//   gates of a half-bridge are never on together. A synchronised
//   over-current input latches a fault that forces every gate off.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   duty       requested duty, taken at the last count of each period
//   sel        commutation select, phase p uses sel[2p+1:2p]
//              00 coast, 01 reverse, 10 forward, 11 brake
//   dead_time  dead-time length in clocks (0 behaves as 1)
//   ovr_curr   asynchronous over-current flag from the comparator
//   flt_clr    level-sensitive fault clear request
//   high       high-side gate enables, one bit per phase
//   low        low-side gate enables, one bit per phase
//   PWM_synch  one-cycle pulse in the cycle where the PWM count is 0
//   fault      latched over-current fault

module mtr_drv_gen #(
  parameter int PWM_W = 11,
  parameter int N_PH  = 3,
  parameter int DT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PWM_W-1:0]  duty,
  input  logic [2*N_PH-1:0] sel,
  input  logic [DT_W-1:0]   dead_time,
  input  logic              ovr_curr,
  input  logic              flt_clr,
  output logic [N_PH-1:0]   high,
  output logic [N_PH-1:0]   low,
  output logic              PWM_synch,
  output logic              fault
);

  typedef enum logic {RUN, DEAD} dt_state_e;

  localparam logic [PWM_W-1:0] CNT_MAX = '1;
  localparam logic [DT_W-1:0]  DT_ONE  = {{(DT_W-1){1'b0}}, 1'b1};

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] duty_q;
  logic             pwm;

  logic             oc_meta;
  logic             oc_s;
  logic             hold;
  logic [DT_W-1:0]  dt_eff;

  logic [1:0]       req      [N_PH];
  logic [1:0]       req_q    [N_PH];
  logic [1:0]       req_prev [N_PH];
  dt_state_e        state     [N_PH];
  dt_state_e        state_nxt [N_PH];
  logic [DT_W-1:0]  dcnt      [N_PH];
  logic [DT_W-1:0]  dcnt_nxt  [N_PH];
  logic [N_PH-1:0]  high_nxt;
  logic [N_PH-1:0]  low_nxt;

  // PWM timebase. duty is only taken on the last count so a new value
  // always starts cleanly at the next period; PWM_synch is registered so
  // it lines up with the cycle where cnt reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      duty_q    <= '0;
      PWM_synch <= 1'b0;
    end else begin
      cnt       <= cnt + 1'b1;
      PWM_synch <= (cnt == CNT_MAX);
      if (cnt == CNT_MAX) begin
        duty_q <= duty;
      end
    end
  end

  assign pwm = (cnt < duty_q);

  // Over-current path: two-flop synchroniser, then a sticky fault that
  // can only be cleared once the synchronised flag has gone away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oc_meta <= 1'b0;
      oc_s    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      oc_meta <= ovr_curr;
      oc_s    <= oc_meta;
      if (oc_s) begin
        fault <= 1'b1;
      end else if (flt_clr) begin
        fault <= 1'b0;
      end
    end
  end

  // Holding on oc_s as well as fault kills the gates on the same edge
  // that sets the fault, rather than one cycle later.
  assign hold   = fault | oc_s;
  assign dt_eff = (dead_time == '0) ? DT_ONE : dead_time;

  // Commutation mux: {hreq, lreq} per phase from the shared PWM.
  always_comb begin
    for (int p = 0; p < N_PH; p++) begin
      req[p] = 2'b00;
      case (sel[2*p +: 2])
        2'b00:   req[p] = 2'b00;
        2'b01:   req[p] = {~pwm, pwm};
        2'b10:   req[p] = {pwm, ~pwm};
        default: req[p] = {1'b0, pwm};
      endcase
    end
  end

  // Dead-time FSM state register. Gate outputs are registered here so
  // the drivers see glitch-free levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < N_PH; p++) begin
        req_q[p]    <= 2'b00;
        req_prev[p] <= 2'b00;
        state[p]    <= DEAD;
        dcnt[p]     <= '0;
      end
      high <= '0;
      low  <= '0;
    end else begin
      for (int p = 0; p < N_PH; p++) begin
        req_q[p]    <= req[p];
        req_prev[p] <= req_q[p];
        state[p]    <= state_nxt[p];
        dcnt[p]     <= dcnt_nxt[p];
      end
      high <= high_nxt;
      low  <= low_nxt;
    end
  end

  // Next state. Any change of the registered request opens (or restarts)
  // a dead window of dt_eff clocks; the window closes on the clock where
  // the counter reads 1, or 0 straight out of reset. A fault pins every
  // phase in DEAD with a full count so a clear always gives a full window.
  always_comb begin
    for (int p = 0; p < N_PH; p++) begin
      state_nxt[p] = state[p];
      dcnt_nxt[p]  = dcnt[p];
      if (hold) begin
        state_nxt[p] = DEAD;
        dcnt_nxt[p]  = dt_eff;
      end else begin
        case (state[p])
          RUN: begin
            if (req_q[p] != req_prev[p]) begin
              state_nxt[p] = DEAD;
              dcnt_nxt[p]  = dt_eff;
            end
          end
          default: begin
            if (req_q[p] != req_prev[p]) begin
              dcnt_nxt[p] = dt_eff;
            end else if (dcnt[p] <= DT_ONE) begin
              state_nxt[p] = RUN;
              dcnt_nxt[p]  = '0;
            end else begin
              dcnt_nxt[p] = dcnt[p] - 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Outputs follow the request only when the phase will be in RUN after
  // this edge; every path into DEAD therefore turns both gates off at once.
  always_comb begin
    high_nxt = '0;
    low_nxt  = '0;
    for (int p = 0; p < N_PH; p++) begin
      if (state_nxt[p] == RUN) begin
        high_nxt[p] = req_q[p][1];
        low_nxt[p]  = req_q[p][0];
      end
    end
  end

endmodule

// File: tb/tb_mtr_drv_gen.sv
// tb_mtr_drv_gen
//   Self-checking bench for mtr_drv_gen. Expected values are pushed to a
//   scoreboard queue when stimulus is applied and popped when the matching
//   measurement of the DUT outputs is available.

module tb_mtr_drv_gen;

  localparam int PWM_W  = 11;
  localparam int N_PH   = 3;
  localparam int DT_W   = 6;
  localparam int PERIOD = 2048;

  logic              clk;
  logic              rst;
  logic [PWM_W-1:0]  duty;
  logic [2*N_PH-1:0] sel;
  logic [DT_W-1:0]   dead_time;
  logic              ovr_curr;
  logic              flt_clr;
  logic [N_PH-1:0]   high;
  logic [N_PH-1:0]   low;
  logic              PWM_synch;
  logic              fault;

  mtr_drv_gen #(.PWM_W(PWM_W), .N_PH(N_PH), .DT_W(DT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .duty      (duty),
    .sel       (sel),
    .dead_time (dead_time),
    .ovr_curr  (ovr_curr),
    .flt_clr   (flt_clr),
    .high      (high),
    .low       (low),
    .PWM_synch (PWM_synch),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  int    overlap_cnt = 0;
  string exp_tag [$];
  int    exp_val [$];

  int    m_hi   [N_PH];
  int    m_lo   [N_PH];
  int    m_both [N_PH];
  int    m_len;

  // Shoot-through watchdog over the whole run.
  always @(posedge clk) begin
    #2;
    if ((high & low) != '0) overlap_cnt++;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic push_exp(input string tag, input int val);
    exp_tag.push_back(tag);
    exp_val.push_back(val);
  endtask

  task automatic pop_check(input int actual);
    if (exp_val.size() == 0) begin
      checkOutput("scoreboard_empty", actual, -1);
    end else begin
      checkOutput(exp_tag.pop_front(), actual, exp_val.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_synch();
    int n = 0;
    while (PWM_synch !== 1'b1 && n < 3*PERIOD) begin
      step();
      n++;
    end
    if (PWM_synch !== 1'b1) checkOutput("synch_timeout", 0, 1);
  endtask

  // Starts on a PWM_synch sample and runs up to the next one, counting
  // gate activity per phase. Optionally changes duty at a given offset.
  task automatic measure_period(input int chg_at, input logic [PWM_W-1:0] new_duty);
    for (int p = 0; p < N_PH; p++) begin
      m_hi[p] = 0;
      m_lo[p] = 0;
      m_both[p] = 0;
    end
    m_len = 0;
    do begin
      for (int p = 0; p < N_PH; p++) begin
        if (high[p] === 1'b1) m_hi[p]++;
        if (low[p] === 1'b1) m_lo[p]++;
        if (high[p] === 1'b0 && low[p] === 1'b0) m_both[p]++;
      end
      if (m_len == chg_at) duty = new_duty;
      step();
      m_len++;
    end while (PWM_synch !== 1'b1 && m_len < 3*PERIOD);
  endtask

  initial begin
    int n;
    int first_drive;
    logic [N_PH-1:0] acc;

    rst       = 1'b1;
    duty      = 11'd512;
    sel       = 6'b101010;
    dead_time = 6'd32;
    ovr_curr  = 1'b0;
    flt_clr   = 1'b0;

    #12;
    push_exp("reset_high", 0);
    push_exp("reset_low", 0);
    push_exp("reset_synch", 0);
    push_exp("reset_fault", 0);
    pop_check(int'(high));
    pop_check(int'(low));
    pop_check(int'(PWM_synch));
    pop_check(int'(fault));

    step();
    rst = 1'b0;
    wait_synch();

    $display("[TB] forward, duty 512, dead time 32");
    push_exp("period_len", PERIOD);
    push_exp("fwd_high0", 480);
    push_exp("fwd_low0", 1504);
    push_exp("fwd_both0", 64);
    measure_period(-1, '0);
    pop_check(m_len);
    pop_check(m_hi[0]);
    pop_check(m_lo[0]);
    pop_check(m_both[0]);

    $display("[TB] duty 512 -> 1024 at cnt 100");
    push_exp("dutychg_cur_high0", 480);
    measure_period(100, 11'd1024);
    pop_check(m_hi[0]);
    push_exp("dutychg_next_high0", 992);
    push_exp("dutychg_next_low0", 992);
    measure_period(-1, '0);
    pop_check(m_hi[0]);
    pop_check(m_lo[0]);

    $display("[TB] modes reverse/brake/coast");
    sel  = 6'b001101;
    duty = 11'd512;
    measure_period(-1, '0);
    push_exp("rev_high0", 1504);
    push_exp("rev_low0", 480);
    push_exp("brake_high1", 0);
    push_exp("brake_low1", 480);
    push_exp("coast_high2", 0);
    push_exp("coast_low2", 0);
    measure_period(-1, '0);
    pop_check(m_hi[0]);
    pop_check(m_lo[0]);
    pop_check(m_hi[1]);
    pop_check(m_lo[1]);
    pop_check(m_hi[2]);
    pop_check(m_lo[2]);

    $display("[TB] dead time 0");
    dead_time = 6'd0;
    sel       = 6'b101010;
    measure_period(-1, '0);
    push_exp("dt0_high0", 511);
    push_exp("dt0_low0", 1535);
    push_exp("dt0_both0", 2);
    measure_period(-1, '0);
    pop_check(m_hi[0]);
    pop_check(m_lo[0]);
    pop_check(m_both[0]);

    $display("[TB] over-current fault");
    dead_time = 6'd32;
    measure_period(-1, '0);
    repeat (300) step();
    ovr_curr = 1'b1;
    push_exp("fault_at_2clk", 0);
    step();
    step();
    pop_check(int'(fault));
    push_exp("fault_at_3clk", 1);
    push_exp("fault_high", 0);
    push_exp("fault_low", 0);
    step();
    pop_check(int'(fault));
    pop_check(int'(high));
    pop_check(int'(low));

    flt_clr = 1'b1;
    acc = '0;
    push_exp("fault_clr_blocked", 1);
    push_exp("fault_hold_out", 0);
    repeat (5) begin
      step();
      acc |= high | low;
    end
    pop_check(int'(fault));
    pop_check(int'(acc));

    flt_clr  = 1'b0;
    ovr_curr = 1'b0;
    repeat (4) step();
    push_exp("fault_no_clr", 1);
    pop_check(int'(fault));

    flt_clr = 1'b1;
    step();
    flt_clr = 1'b0;
    push_exp("fault_cleared", 0);
    pop_check(int'(fault));
    n = 0;
    while (high[0] === 1'b0 && low[0] === 1'b0 && n < 500) begin
      n++;
      step();
    end
    push_exp("dead_after_clr", 32);
    push_exp("resume_high0", 1);
    pop_check(n);
    pop_check(int'(high[0]));

    $display("[TB] async reset mid-period");
    push_exp("pre_rst_high0", 1);
    pop_check(int'(high[0]));
    #3;
    rst = 1'b1;
    #1;
    push_exp("arst_high", 0);
    push_exp("arst_low", 0);
    push_exp("arst_synch", 0);
    push_exp("arst_fault", 0);
    pop_check(int'(high));
    pop_check(int'(low));
    pop_check(int'(PWM_synch));
    pop_check(int'(fault));
    #1;
    rst = 1'b0;
    n = 0;
    first_drive = -1;
    push_exp("synch_after_rst", PERIOD);
    push_exp("first_drive_after_rst", 34);
    while (PWM_synch !== 1'b1 && n < 3*PERIOD) begin
      step();
      n++;
      if (first_drive < 0 && (high[0] === 1'b1 || low[0] === 1'b1)) first_drive = n;
    end
    pop_check(n);
    pop_check(first_drive);

    checkOutput("no_overlap", overlap_cnt, 0);
    checkOutput("scoreboard_drained", exp_val.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
